// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges memory waits, load-use, divider
// occupancy and EX branch resolution into per-stage stalls and flush strobes.
module pipe_hazard_ctrl #(
    parameter int unsigned STAGE_NUM = 6,
    parameter int unsigned DIV_LAT   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 im_stall,
    input  logic                 dm_stall,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_rs1_en,
    input  logic                 id_rs2_en,
    input  logic                 branch_taken,
    input  logic                 div_start,
    output logic [STAGE_NUM-1:0] stall,
    output logic                 redirect,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 div_busy,
    output logic                 div_done
);

    localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    localparam logic [5:0] STALL_DM   = 6'b011111;
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_IM   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pend, pend_next;

    logic             load_use;
    logic             div_occ;
    logic             ex_hold;
    logic             accept;
    logic [5:0]       stall_pat;

    // State, occupancy counter and pending-flush flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
        end
    end

    // Divider occupancy FSM; the counter saturates at zero
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (div_start && !dm_stall) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(DIV_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!dm_stall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Hazard merge; a branch may only leave EX when EX is not held
    always_comb begin
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_en && (id_rs1 == ex_rd)) ||
                     (id_rs2_en && (id_rs2 == ex_rd)));
        div_occ   = (state == BUSY) || ((state == IDLE) && div_start);
        ex_hold   = dm_stall || (state == BUSY) || ((state == IDLE) && div_start);
        accept    = branch_taken && !ex_hold;
        stall_pat = STALL_NONE;
        if (dm_stall) begin
            stall_pat = STALL_DM;
        end else if (div_occ) begin
            stall_pat = STALL_DIV;
        end else if (load_use && !accept) begin
            stall_pat = STALL_LU;
        end else if (im_stall) begin
            stall_pat = STALL_IM;
        end
    end

    // A redirect during an outstanding fetch leaves one wrong-path word to drop
    always_comb begin
        pend_next = pend;
        if (accept && im_stall) begin
            pend_next = 1'b1;
        end else if (pend && !im_stall) begin
            pend_next = 1'b0;
        end
    end

    assign stall    = STAGE_NUM'(stall_pat);
    assign redirect = accept;
    assign flush_id = accept;
    assign flush_if = accept || (pend && !im_stall);
    assign div_busy = (state == BUSY);
    assign div_done = (state == DONE);

endmodule
